sr_ff_bank: RTL and testbench

//   Parametrised, edge-triggered successor to the single-bit clocked SR latch.

---
 rtl/sr_ff_bank.sv | 97 +++++++++
 tb/tb_sr_ff_bank.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH edge-triggered bistables sharing one clock and a runtime mode (SR/JK/D/T).
// SR-mode S=R=1 collisions resolve by SR_PRIORITY and are logged in a sticky flag and saturating counter.
module sr_ff_bank #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int SR_PRIORITY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             chg
);

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d;

    mode_e            mode_s;
    logic [WIDTH-1:0] hold_bits, set_bits, both_bits, pol_bits;
    logic             illegal;

    assign mode_s    = mode_e'(mode);
    assign hold_bits = q_q & ~(s | r);
    assign set_bits  = s & ~r;
    assign both_bits = s & r;
    assign illegal   = en && (mode_s == MODE_SR) && (|both_bits);

    // Value a colliding SR bit takes: 0 keeps q, 1 forces set, 2 forces reset.
    always_comb begin
        pol_bits = q_q;
        if (SR_PRIORITY == 1) pol_bits = '1;
        else if (SR_PRIORITY == 2) pol_bits = '0;
    end

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_s)
                MODE_SR: q_d = hold_bits | set_bits | (both_bits & pol_bits);
                MODE_JK: q_d = hold_bits | set_bits | (both_bits & ~q_q);
                MODE_D:  q_d = s;
                MODE_T:  q_d = ~r & (q_q ^ s);
                default: q_d = q_q;
            endcase
        end
    end

    // A same-cycle clear is applied before the event is counted.
    always_comb begin
        err_d = err_clr ? 1'b0 : err_q;
        cnt_d = err_clr ? '0 : cnt_q;
        if (illegal) begin
            err_d = 1'b1;
            if (cnt_d != CNT_MAX) cnt_d = cnt_d + 1'b1;
        end
        chg_d = (q_d != q_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign err     = err_q;
    assign err_cnt = cnt_q;
    assign chg     = chg_q;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Drives four sr_ff_bank instances (hold / set-wins / reset-wins / 2-bit counter) with shared stimulus
// and compares each against a per-bit behavioural model through an expected-value queue.
module tb_sr_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] s;
    logic [7:0] r;
    logic       err_clr;

    logic [7:0] q_w   [4];
    logic [7:0] qn_w  [4];
    logic       err_w [4];
    logic [7:0] cnt_w [4];
    logic       chg_w [4];
    logic [7:0] cnt0, cnt1, cnt2;
    logic [1:0] cnt3;

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = cnt1;
    assign cnt_w[2] = cnt2;
    assign cnt_w[3] = {6'b0, cnt3};

    sr_ff_bank #(.WIDTH(8), .CNT_W(8), .SR_PRIORITY(0)) u_p0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
        .q(q_w[0]), .qn(qn_w[0]), .err(err_w[0]), .err_cnt(cnt0), .chg(chg_w[0]));
    sr_ff_bank #(.WIDTH(8), .CNT_W(8), .SR_PRIORITY(1)) u_p1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
        .q(q_w[1]), .qn(qn_w[1]), .err(err_w[1]), .err_cnt(cnt1), .chg(chg_w[1]));
    sr_ff_bank #(.WIDTH(8), .CNT_W(8), .SR_PRIORITY(2)) u_p2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
        .q(q_w[2]), .qn(qn_w[2]), .err(err_w[2]), .err_cnt(cnt2), .chg(chg_w[2]));
    sr_ff_bank #(.WIDTH(8), .CNT_W(2), .SR_PRIORITY(0)) u_c2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .s(s), .r(r), .err_clr(err_clr),
        .q(q_w[3]), .qn(qn_w[3]), .err(err_w[3]), .err_cnt(cnt3), .chg(chg_w[3]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // scoreboard: {q, qn, err, err_cnt, chg}
    logic [25:0] exp_q[$];

    logic [7:0] m_q   [4];
    logic       m_err [4];
    logic [7:0] m_cnt [4];
    logic       m_chg [4];
    int         prio    [4] = '{0, 1, 2, 0};
    logic [7:0] cnt_max [4] = '{8'd255, 8'd255, 8'd255, 8'd3};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [25:0] observed(input int i);
        return {q_w[i], qn_w[i], err_w[i], cnt_w[i], chg_w[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i] = 8'h00; m_err[i] = 1'b0; m_cnt[i] = 8'h00; m_chg[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [7:0] nq;
        logic       ill;
        for (int i = 0; i < 4; i++) begin
            nq  = m_q[i];
            ill = 1'b0;
            if (en) begin
                for (int b = 0; b < 8; b++) begin
                    case (mode)
                        2'b00: begin
                            if (s[b] && !r[b]) nq[b] = 1'b1;
                            else if (!s[b] && r[b]) nq[b] = 1'b0;
                            else if (s[b] && r[b]) begin
                                ill = 1'b1;
                                if (prio[i] == 1) nq[b] = 1'b1;
                                else if (prio[i] == 2) nq[b] = 1'b0;
                            end
                        end
                        2'b01: begin
                            if (s[b] && r[b]) nq[b] = ~m_q[i][b];
                            else if (s[b]) nq[b] = 1'b1;
                            else if (r[b]) nq[b] = 1'b0;
                        end
                        2'b10: nq[b] = s[b];
                        default: begin
                            if (r[b]) nq[b] = 1'b0;
                            else if (s[b]) nq[b] = ~m_q[i][b];
                        end
                    endcase
                end
            end
            if (err_clr) begin
                m_err[i] = 1'b0;
                m_cnt[i] = 8'h00;
            end
            if (ill) begin
                m_err[i] = 1'b1;
                if (m_cnt[i] < cnt_max[i]) m_cnt[i] = m_cnt[i] + 8'd1;
            end
            m_chg[i] = (nq != m_q[i]);
            m_q[i]   = nq;
            exp_q.push_back({m_q[i], ~m_q[i], m_err[i], m_cnt[i], m_chg[i]});
        end
    endtask

    // driver: apply inputs on the falling edge, compare 1 ns after the rising edge
    task automatic step(input logic e, input logic [1:0] md, input logic [7:0] sv,
                        input logic [7:0] rv, input logic clr);
        logic [25:0] exp;
        @(negedge clk);
        en = e; mode = md; s = sv; r = rv; err_clr = clr;
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) begin
                check($sformatf("sb_empty_u%0d", i), 32'd0, 32'd1);
            end else begin
                exp = exp_q.pop_front();
                check($sformatf("sb_u%0d", i), 32'(observed(i)), 32'(exp));
            end
        end
    endtask

    // async reset asserted between edges; effect must be visible before any clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_q_u%0d", i),   32'(q_w[i]),   32'h00);
            check($sformatf("rst_qn_u%0d", i),  32'(qn_w[i]),  32'hFF);
            check($sformatf("rst_err_u%0d", i), 32'(err_w[i]), 32'h0);
            check($sformatf("rst_cnt_u%0d", i), 32'(cnt_w[i]), 32'h0);
            check($sformatf("rst_chg_u%0d", i), 32'(chg_w[i]), 32'h0);
        end
        model_reset();
        en = 1'b0; mode = 2'b00; s = 8'h00; r = 8'h00; err_clr = 1'b0;
        @(posedge clk);
        #1;
        check("rst_hold_q", 32'(q_w[0]), 32'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] sr_s [7] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF};
    logic [7:0] sr_r [7] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
    logic [7:0] sr_q [7] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [1:0] c2_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [7:0] jk_exp [3] = '{8'hFF, 8'h00, 8'hFF};

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00; s = 8'h00; r = 8'h00; err_clr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // SR sequence with hold policy
        for (int k = 0; k < 7; k++) begin
            step(1'b1, 2'b00, sr_s[k], sr_r[k], 1'b0);
            check($sformatf("sr_seq_q%0d", k), 32'(q_w[0]), 32'(sr_q[k]));
        end
        check("sr_seq_err", 32'(err_w[0]), 32'h1);
        check("sr_seq_cnt", 32'(cnt_w[0]), 32'h1);

        // SR collision policies
        do_reset();
        step(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
        check("set_wins_q", 32'(q_w[1]), 32'hFF);
        check("set_wins_cnt", 32'(cnt_w[1]), 32'h1);
        do_reset();
        step(1'b1, 2'b00, 8'hFF, 8'h00, 1'b0);
        step(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0);
        check("rst_wins_q", 32'(q_w[2]), 32'h00);
        check("rst_wins_cnt", 32'(cnt_w[2]), 32'h1);

        // JK toggle and T with clear
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0);
            check($sformatf("jk_q%0d", k), 32'(q_w[0]), 32'(jk_exp[k]));
            check($sformatf("jk_err%0d", k), 32'(err_w[0]), 32'h0);
        end
        do_reset();
        step(1'b1, 2'b11, 8'h0F, 8'h01, 1'b0);
        check("t_q", 32'(q_w[0]), 32'h0E);

        // Counter saturation and clear interplay on the 2-bit counter
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 2'b00, 8'h81, 8'h81, 1'b0);
            check($sformatf("sat_cnt%0d", k), 32'(cnt_w[3]), 32'(c2_exp[k]));
        end
        step(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b1);
        check("clr_evt_cnt", 32'(cnt_w[3]), 32'h1);
        check("clr_evt_err", 32'(err_w[3]), 32'h1);
        step(1'b1, 2'b00, 8'h00, 8'h00, 1'b1);
        check("clr_cnt", 32'(cnt_w[3]), 32'h0);
        check("clr_err", 32'(err_w[3]), 32'h0);

        // Enable, chg, and an async reset while err is set
        do_reset();
        step(1'b1, 2'b00, 8'h01, 8'h01, 1'b0);
        step(1'b0, 2'b10, 8'hAA, 8'h00, 1'b0);
        check("en0_q", 32'(q_w[0]), 32'h00);
        check("en0_chg", 32'(chg_w[0]), 32'h0);
        step(1'b1, 2'b10, 8'hAA, 8'h00, 1'b0);
        check("en1_q", 32'(q_w[0]), 32'hAA);
        check("en1_chg", 32'(chg_w[0]), 32'h1);
        check("pre_rst_err", 32'(err_w[0]), 32'h1);
        do_reset();

        // Random mix across all modes
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) == 0));
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
